// File: rtl/redun_to_canon_stream.sv
// Serial carry resolver: one double-width redundant product in,
// canonical WORD_LEN words out on a valid/ready stream, LSW first.
module redun_to_canon_stream #(
  parameter  int NUM_ELEMENTS = 66,
  parameter  int BIT_LEN      = 17,
  parameter  int WORD_LEN     = 16,
  localparam int CARRY_LEN    = BIT_LEN - WORD_LEN + 1,
  localparam int IDX_LEN      = $clog2(NUM_ELEMENTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_LEN-1:0]   in_digits [NUM_ELEMENTS],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_LEN-1:0]  out_word,
  output logic                 out_last,
  output logic [CARRY_LEN-1:0] out_carry,
  output logic                 busy
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(NUM_ELEMENTS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [IDX_LEN-1:0]   r_idx;
  logic [CARRY_LEN-1:0] r_carry;
  logic [BIT_LEN-1:0]   r_buf [NUM_ELEMENTS];

  logic                 w_cap;
  logic                 w_acc;
  logic                 w_end;
  logic [IDX_LEN-1:0]   w_nidx;
  logic [BIT_LEN:0]     w_sum;
  logic [BIT_LEN:0]     w_sum0;

  assign w_cap  = in_valid & (r_state == S_IDLE);
  assign w_acc  = out_ready & (r_state == S_RUN);
  assign w_end  = w_acc & (r_idx == LAST_IDX);
  assign w_nidx = r_idx + IDX_LEN'(1);

  // r_carry is the carry out of the word currently presented
  assign w_sum  = {1'b0, r_buf[w_nidx]}
                + {{(BIT_LEN + 1 - CARRY_LEN){1'b0}}, r_carry};
  assign w_sum0 = {1'b0, in_digits[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (w_end)    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_RUN);
    busy      = (r_state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_buf <= in_digits;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      r_carry   <= '0;
      out_word  <= '0;
      out_last  <= 1'b0;
      out_carry <= '0;
    end else if (w_cap) begin
      r_idx     <= '0;
      r_carry   <= w_sum0[BIT_LEN:WORD_LEN];
      out_word  <= w_sum0[WORD_LEN-1:0];
      out_last  <= (NUM_ELEMENTS == 1);
      out_carry <= (NUM_ELEMENTS == 1) ? w_sum0[BIT_LEN:WORD_LEN] : '0;
    end else if (w_acc) begin
      if (w_end) begin
        out_last  <= 1'b0;
        out_carry <= '0;
      end else begin
        r_idx     <= w_nidx;
        r_carry   <= w_sum[BIT_LEN:WORD_LEN];
        out_word  <= w_sum[WORD_LEN-1:0];
        out_last  <= (w_nidx == LAST_IDX);
        out_carry <= (w_nidx == LAST_IDX) ? w_sum[BIT_LEN:WORD_LEN] : '0;
      end
    end
  end

endmodule

// File: tb/tb_redun_to_canon_stream.sv
// Scoreboard bench for redun_to_canon_stream: big-integer reference
// model feeds an expected queue, a negedge monitor pops and compares.
module tb_redun_to_canon_stream;

  localparam int N  = 66;
  localparam int BL = 17;
  localparam int WL = 16;
  localparam int CL = 2;
  localparam int TW = WL * N + CL;

  typedef struct {
    logic [WL-1:0] word;
    logic          last;
    logic [CL-1:0] carry;
  } exp_t;

  logic          clk = 0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [BL-1:0] dig [N];
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_word;
  logic          out_last;
  logic [CL-1:0] out_carry;
  logic          busy;

  redun_to_canon_stream dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digits (dig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   acc = 0;
  bit   rand_mode = 0;
  bit   chk_after = 0;

  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic void tmo(string n);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected event at %0t", n, $time);
  endfunction

  // Reference: weighted sum of all digits as one wide integer
  task automatic push_expected(input logic [BL-1:0] d [N]);
    logic [TW-1:0] tot;
    exp_t e;
    tot = '0;
    for (int i = 0; i < N; i++) tot += TW'(d[i]) << (WL * i);
    for (int i = 0; i < N; i++) begin
      e.word  = tot[WL*i +: WL];
      e.last  = (i == N - 1);
      e.carry = (i == N - 1) ? tot[TW-1 -: CL] : '0;
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor
  logic [WL-1:0] h_w;
  logic          h_l;
  logic [CL-1:0] h_c;
  bit            hold = 0;
  bit            prev = 0;
  exp_t          pe;

  always @(negedge clk) begin
    if (reset) begin
      hold = 0;
      prev = 0;
    end else begin
      if (prev) chk("no_bubble", 64'(out_valid), 64'd1);
      prev = 0;
      if (hold && out_valid) begin
        chk("stall_word", 64'(out_word), 64'(h_w));
        chk("stall_last", 64'(out_last), 64'(h_l));
        chk("stall_carry", 64'(out_carry), 64'(h_c));
      end
      hold = 0;
      if (out_valid && !out_ready) begin
        hold = 1;
        h_w = out_word;
        h_l = out_last;
        h_c = out_carry;
      end
      if (out_valid && out_ready) begin
        acc++;
        if (q.size() == 0) begin
          tmo("unexpected_beat");
        end else begin
          pe = q.pop_front();
          chk("word", 64'(out_word), 64'(pe.word));
          chk("last", 64'(out_last), 64'(pe.last));
          if (pe.last) begin
            chk("carry", 64'(out_carry), 64'(pe.carry));
            chk_after = 1;
          end
          prev = !out_last;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_after) begin
      chk_after = 0;
      chk("ready_after_last", 64'(in_ready), 64'd1);
      chk("valid_after_last", 64'(out_valid), 64'd0);
    end
  end

  task automatic capture();
    bit r;
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      cnt++;
    end while (!r && cnt < 500);
    #1;
    in_valid = 0;
    if (!r) tmo("capture");
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("busy_run", 64'(busy), 64'd1);
  endtask

  task automatic send();
    push_expected(dig);
    in_valid = 1;
    capture();
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!(q.size() == 0 && in_ready) && cnt < 2000);
    if (cnt >= 2000) tmo("wait_idle");
  endtask

  task automatic check_reset_outs(string n);
    chk({n, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({n, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({n, "_busy"}, 64'(busy), 64'd0);
    chk({n, "_out_carry"}, 64'(out_carry), 64'd0);
    chk({n, "_out_last"}, 64'(out_last), 64'd0);
    chk({n, "_out_word"}, 64'(out_word), 64'd0);
  endtask

  task automatic fill(input logic [BL-1:0] v);
    for (int i = 0; i < N; i++) dig[i] = v;
  endtask

  initial begin
    int a0;
    int cnt;
    reset     = 1;
    in_valid  = 0;
    out_ready = 1;
    fill('0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("por");
    reset = 0;
    @(posedge clk);
    #1;

    // Two low digits saturated
    fill('0);
    dig[0] = 17'h1FFFF;
    dig[1] = 17'h1FFFF;
    send();
    wait_idle();

    // All digits saturated: top carry is 2
    fill(17'h1FFFF);
    send();
    wait_idle();

    // Random digits, random backpressure
    rand_mode = 1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) dig[i] = BL'($urandom);
      send();
      wait_idle();
    end

    // New product offered while busy
    for (int i = 0; i < N; i++) dig[i] = BL'($urandom);
    send();
    for (int i = 0; i < N; i++) dig[i] = BL'($urandom);
    push_expected(dig);
    in_valid = 1;
    @(negedge clk);
    chk("ready_while_busy", 64'(in_ready), 64'd0);
    capture();
    wait_idle();
    rand_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-stream after two accepted beats
    fill(17'h1FFFF);
    send();
    a0 = acc;
    cnt = 0;
    while (acc < a0 + 2 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (acc < a0 + 2) tmo("two_beats");
    @(posedge clk);
    #3;
    reset = 1;
    q.delete();
    #1;
    check_reset_outs("async");
    @(posedge clk);
    #1;
    chk("valid_in_reset", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 0;
    fill('0);
    dig[0] = 17'h00005;
    send();
    wait_idle();

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
